// File: rtl/gpio_irq_pkg.sv
// gpio_irq_pkg: shared definitions for the gpio_irq block.
//   - byte offsets of the register map (decoded from addr[5:0])
//   - warm-up count after which edge capture is enabled
//   - register-select enum and the offset decoder
package gpio_irq_pkg;

    localparam logic [5:0] OFF_OUT     = 6'h00;
    localparam logic [5:0] OFF_DIR     = 6'h04;
    localparam logic [5:0] OFF_PIN     = 6'h08;
    localparam logic [5:0] OFF_SET     = 6'h0C;
    localparam logic [5:0] OFF_CLR     = 6'h10;
    localparam logic [5:0] OFF_IRQ_EN  = 6'h14;
    localparam logic [5:0] OFF_RISE_EN = 6'h18;
    localparam logic [5:0] OFF_FALL_EN = 6'h1C;
    localparam logic [5:0] OFF_STATUS  = 6'h20;

    // Edge capture is held off until the warm-up counter reaches this value,
    // so the sync chain filling up from its reset value is not seen as an edge.
    localparam logic [1:0] WARMUP_COUNT = 2'd3;

    typedef enum logic [3:0] {
        SEL_OUT,
        SEL_DIR,
        SEL_PIN,
        SEL_SET,
        SEL_CLR,
        SEL_IRQ_EN,
        SEL_RISE_EN,
        SEL_FALL_EN,
        SEL_STATUS,
        SEL_NONE
    } reg_sel_e;

    // Exact match on the low six address bits; anything unaligned or outside
    // 0x00..0x20 falls through to SEL_NONE.
    function automatic reg_sel_e decode_offset(input logic [5:0] off);
        reg_sel_e sel;
        case (off)
            OFF_OUT:     sel = SEL_OUT;
            OFF_DIR:     sel = SEL_DIR;
            OFF_PIN:     sel = SEL_PIN;
            OFF_SET:     sel = SEL_SET;
            OFF_CLR:     sel = SEL_CLR;
            OFF_IRQ_EN:  sel = SEL_IRQ_EN;
            OFF_RISE_EN: sel = SEL_RISE_EN;
            OFF_FALL_EN: sel = SEL_FALL_EN;
            OFF_STATUS:  sel = SEL_STATUS;
            default:     sel = SEL_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/gpio_irq_sync.sv
// gpio_irq_sync: three-flop input chain with edge vectors.
//   clk     in    clock
//   rst_ni  in    synchronous active-low reset
//   pin_i   in    asynchronous pad inputs
//   sync_o  out   synchronised input (second flop)
//   rise_o  out   per-bit rising edge, second flop high / third flop low
//   fall_o  out   per-bit falling edge, second flop low / third flop high
module gpio_irq_sync #(
    parameter int Width = 16
) (
    input  logic             clk,
    input  logic             rst_ni,
    input  logic [Width-1:0] pin_i,
    output logic [Width-1:0] sync_o,
    output logic [Width-1:0] rise_o,
    output logic [Width-1:0] fall_o
);

    logic [Width-1:0] s1_q;
    logic [Width-1:0] s2_q;
    logic [Width-1:0] s3_q;

    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= pin_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign sync_o = s2_q;

    for (genvar gi = 0; gi < Width; gi++) begin : g_edge
        assign rise_o[gi] =  s2_q[gi] & ~s3_q[gi];
        assign fall_o[gi] = ~s2_q[gi] &  s3_q[gi];
    end

endmodule

// File: rtl/gpio_irq.sv
// gpio_irq: APB subordinate GPIO with direction, atomic set/clear and
// maskable edge interrupts.
//   clk, nReset          clock, synchronous active-low reset
//   addr, wData, write,  APB request (zero wait states)
//   sel, enable
//   rData, readyOut,     APB response; rData/subErr are combinational in the
//   subErr               access phase and 0 otherwise
//   pinIn                asynchronous pad inputs
//   pinOut, pinOe        output data and drive-enable registers
//   irq                  |(STATUS & IRQ_EN)
module gpio_irq
    import gpio_irq_pkg::*;
#(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32,
    parameter int Width     = 16
) (
    input  logic                 clk,
    input  logic                 nReset,
    input  logic [AddrWidth-1:0] addr,
    input  logic [DataWidth-1:0] wData,
    input  logic                 write,
    input  logic                 sel,
    input  logic                 enable,
    output logic [DataWidth-1:0] rData,
    output logic                 readyOut,
    output logic                 subErr,
    input  logic [Width-1:0]     pinIn,
    output logic [Width-1:0]     pinOut,
    output logic [Width-1:0]     pinOe,
    output logic                 irq
);

    logic [Width-1:0] out_q, out_d;
    logic [Width-1:0] dir_q, dir_d;
    logic [Width-1:0] irq_en_q, irq_en_d;
    logic [Width-1:0] rise_en_q, rise_en_d;
    logic [Width-1:0] fall_en_q, fall_en_d;
    logic [Width-1:0] status_q, status_d;
    logic [1:0]       warm_q, warm_d;

    logic [Width-1:0] pin_sync, rise, fall;

    gpio_irq_sync #(.Width(Width)) u_sync (
        .clk    (clk),
        .rst_ni (nReset),
        .pin_i  (pinIn),
        .sync_o (pin_sync),
        .rise_o (rise),
        .fall_o (fall)
    );

    // Only addr[5:0] and wData[Width-1:0] carry meaning.
    logic unused_bits;
    assign unused_bits = ^{addr, wData};

    logic             access, acc_err, wr_en, rd_en;
    reg_sel_e         reg_sel;
    logic [Width-1:0] wdata_w, rd_val, w1c, edge_hits, capture_mask;

    assign access   = sel & enable;
    assign reg_sel  = decode_offset(addr[5:0]);
    assign wdata_w  = wData[Width-1:0];
    assign readyOut = sel;

    always_comb begin
        acc_err = 1'b0;
        if (reg_sel == SEL_NONE) begin
            acc_err = 1'b1;
        end else if (write && reg_sel == SEL_PIN) begin
            acc_err = 1'b1;
        end else if (!write && (reg_sel == SEL_SET || reg_sel == SEL_CLR)) begin
            acc_err = 1'b1;
        end
    end

    assign subErr = access & acc_err;
    assign wr_en  = access &  write & ~acc_err;
    assign rd_en  = access & ~write & ~acc_err;

    always_comb begin
        rd_val = '0;
        case (reg_sel)
            SEL_OUT:     rd_val = out_q;
            SEL_DIR:     rd_val = dir_q;
            SEL_PIN:     rd_val = pin_sync;
            SEL_IRQ_EN:  rd_val = irq_en_q;
            SEL_RISE_EN: rd_val = rise_en_q;
            SEL_FALL_EN: rd_val = fall_en_q;
            SEL_STATUS:  rd_val = status_q;
            default:     rd_val = '0;
        endcase
    end

    always_comb begin
        rData = '0;
        if (rd_en) begin
            rData[Width-1:0] = rd_val;
        end
    end

    always_comb begin
        out_d     = out_q;
        dir_d     = dir_q;
        irq_en_d  = irq_en_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        w1c       = '0;
        if (wr_en) begin
            case (reg_sel)
                SEL_OUT:     out_d     = wdata_w;
                SEL_DIR:     dir_d     = wdata_w;
                SEL_SET:     out_d     = out_q | wdata_w;
                SEL_CLR:     out_d     = out_q & ~wdata_w;
                SEL_IRQ_EN:  irq_en_d  = wdata_w;
                SEL_RISE_EN: rise_en_d = wdata_w;
                SEL_FALL_EN: fall_en_d = wdata_w;
                SEL_STATUS:  w1c       = wdata_w;
                default:     ;
            endcase
        end
    end

    // New edges are OR-ed in after the W1C mask, so an edge landing on the
    // same clock as a clear of that bit keeps it set.
    assign capture_mask = (warm_q == WARMUP_COUNT) ? '1 : '0;
    assign edge_hits    = ((rise & rise_en_q) | (fall & fall_en_q)) & capture_mask;
    assign status_d     = (status_q & ~w1c) | edge_hits;
    assign warm_d       = (warm_q == WARMUP_COUNT) ? warm_q : warm_q + 2'd1;

    always_ff @(posedge clk) begin
        if (!nReset) begin
            out_q     <= '0;
            dir_q     <= '0;
            irq_en_q  <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
            warm_q    <= '0;
        end else begin
            out_q     <= out_d;
            dir_q     <= dir_d;
            irq_en_q  <= irq_en_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            status_q  <= status_d;
            warm_q    <= warm_d;
        end
    end

    assign pinOut = out_q;
    assign pinOe  = dir_q;
    assign irq    = |(status_q & irq_en_q);

endmodule

// File: tb/tb_gpio_irq.sv
module tb_gpio_irq;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int W  = 16;

    localparam logic [31:0] A_OUT = 32'h00;
    localparam logic [31:0] A_DIR = 32'h04;
    localparam logic [31:0] A_PIN = 32'h08;
    localparam logic [31:0] A_SET = 32'h0C;
    localparam logic [31:0] A_CLR = 32'h10;
    localparam logic [31:0] A_IEN = 32'h14;
    localparam logic [31:0] A_REN = 32'h18;
    localparam logic [31:0] A_FEN = 32'h1C;
    localparam logic [31:0] A_ST  = 32'h20;

    logic          clk = 1'b0;
    logic          nReset;
    logic [AW-1:0] addr;
    logic [DW-1:0] wData;
    logic          write;
    logic          sel;
    logic          enable;
    logic [DW-1:0] rData;
    logic          readyOut;
    logic          subErr;
    logic [W-1:0]  pinIn;
    logic [W-1:0]  pinOut;
    logic [W-1:0]  pinOe;
    logic          irq;

    gpio_irq #(.AddrWidth(AW), .DataWidth(DW), .Width(W)) dut (
        .clk      (clk),
        .nReset   (nReset),
        .addr     (addr),
        .wData    (wData),
        .write    (write),
        .sel      (sel),
        .enable   (enable),
        .rData    (rData),
        .readyOut (readyOut),
        .subErr   (subErr),
        .pinIn    (pinIn),
        .pinOut   (pinOut),
        .pinOe    (pinOe),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        logic          chk_data;
        string         name;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Monitor: every access phase pops one expectation and compares.
    always @(negedge clk) begin
        exp_t e;
        if (nReset && sel && enable) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_access: addr=0x%0h rdata=0x%0h err=%0b, no expectation queued",
                         addr, rData, subErr);
            end else begin
                e = sb_q.pop_front();
                $display("apb %s addr=0x%0h write=%0b rdata=0x%0h err=%0b ready=%0b",
                         e.name, addr, write, rData, subErr, readyOut);
                if (subErr !== e.err || readyOut !== 1'b1 ||
                    (e.chk_data && rData !== e.rdata)) begin
                    errors++;
                    $display("FAIL %s: got rdata=0x%0h err=%0b ready=%0b, expected rdata=0x%0h err=%0b ready=1",
                             e.name, rData, subErr, readyOut, e.rdata, e.err);
                end
            end
        end
    end

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        $display("pin %s value=0x%0h", name, act);
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Both tasks start at #1 after an edge: setup phase now, access phase
    // after the next edge, completion (write commit) on the edge after that.
    task automatic apb_write(input logic [31:0] a, input logic [31:0] d,
                             input logic exp_err, input string name);
        exp_t e;
        sel = 1'b1; enable = 1'b0; write = 1'b1; addr = a; wData = d;
        @(posedge clk); #1;
        enable = 1'b1;
        e.rdata = '0; e.err = exp_err; e.chk_data = exp_err; e.name = name;
        sb_q.push_back(e);
        @(posedge clk); #1;
        sel = 1'b0; enable = 1'b0; write = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] a, input logic [31:0] exp,
                            input logic exp_err, input string name);
        exp_t e;
        sel = 1'b1; enable = 1'b0; write = 1'b0; addr = a; wData = '0;
        @(posedge clk); #1;
        enable = 1'b1;
        e.rdata = exp; e.err = exp_err; e.chk_data = 1'b1; e.name = name;
        sb_q.push_back(e);
        @(posedge clk); #1;
        sel = 1'b0; enable = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        sel = 0; enable = 0; write = 0; addr = '0; wData = '0;
        pinIn = '0; nReset = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1 nReset = 1'b1;
        check_val("rst_pinout", pinOut, 0);
        check_val("rst_pinoe",  pinOe,  0);
        check_val("rst_irq",    irq,    0);
        check_val("rst_subErr", subErr, 0);
        idle(4);
        apb_read(A_OUT, 0, 0, "rst_out");
        apb_read(A_DIR, 0, 0, "rst_dir");
        apb_read(A_PIN, 0, 0, "rst_pin");
        apb_read(A_IEN, 0, 0, "rst_irq_en");
        apb_read(A_REN, 0, 0, "rst_rise_en");
        apb_read(A_FEN, 0, 0, "rst_fall_en");
        apb_read(A_ST,  0, 0, "rst_status");

        // Direction and set/clear
        apb_write(A_DIR, 32'h0000_00FF, 0, "wr_dir");
        check_val("pinoe_ff", pinOe, 32'h00FF);
        apb_write(A_OUT, 32'h0000_00F0, 0, "wr_out");
        check_val("pinout_f0", pinOut, 32'h00F0);
        apb_write(A_SET, 32'h0000_000F, 0, "wr_set");
        check_val("pinout_ff", pinOut, 32'h00FF);
        apb_write(A_CLR, 32'h0000_0030, 0, "wr_clr");
        check_val("pinout_cf", pinOut, 32'h00CF);
        apb_read(A_OUT, 32'h0000_00CF, 0, "rd_out_cf");
        apb_read(A_DIR, 32'h0000_00FF, 0, "rd_dir_ff");

        // Rising-edge interrupt on bit 0 with exact latency
        apb_write(A_REN, 32'h0000_0001, 0, "wr_rise_en");
        apb_write(A_IEN, 32'h0000_0001, 0, "wr_irq_en");
        pinIn = 16'h0001;            // set up before edge N
        @(posedge clk); #1;          // after N
        fork
            apb_read(A_PIN, 32'h0000_0001, 0, "pin_after_n1");
            begin
                @(posedge clk); #2;  // after N+1
                check_val("irq_at_n1", irq, 0);
            end
        join
        check_val("irq_at_n2", irq, 1);   // after N+2
        apb_read(A_ST, 32'h0000_0001, 0, "status_rise");
        apb_write(A_ST, 32'h0000_0001, 0, "w1c_bit0");
        check_val("irq_after_w1c", irq, 0);
        apb_read(A_ST, 32'h0000_0000, 0, "status_cleared");

        // Falling edge on bit 3 colliding with W1C of bit 3
        apb_write(A_FEN, 32'h0000_0008, 0, "wr_fall_en");
        pinIn = 16'h0009;
        idle(4);
        pinIn = 16'h0001;
        idle(4);
        apb_read(A_ST, 32'h0000_0008, 0, "status_fall");
        check_val("irq_masked_bit3", irq, 0);
        apb_write(A_ST, 32'h0000_0008, 0, "w1c_bit3");
        apb_read(A_ST, 32'h0000_0000, 0, "status_bit3_clr");
        pinIn = 16'h0009;
        idle(4);
        pinIn = 16'h0001;            // before edge N; capture on N+2
        @(posedge clk); #1;
        apb_write(A_ST, 32'h0000_0008, 0, "w1c_collide");  // commits on N+2
        apb_read(A_ST, 32'h0000_0008, 0, "status_collide");
        apb_write(A_ST, 32'h0000_0008, 0, "w1c_bit3_again");
        apb_read(A_ST, 32'h0000_0000, 0, "status_final_clr");

        // Error accesses change nothing and return zero
        apb_read (32'h0000_0024, 0, 1, "err_rd_24");
        apb_write(A_PIN, 32'h0000_FFFF, 1, "err_wr_pin");
        apb_write(32'h0000_0002, 32'h0000_FFFF, 1, "err_wr_02");
        apb_read (A_SET, 0, 1, "err_rd_set");
        apb_read (A_OUT, 32'h0000_00CF, 0, "out_unchanged");
        apb_read (A_PIN, 32'h0000_0001, 0, "pin_unchanged");
        check_val("pinout_unchanged", pinOut, 32'h00CF);

        // Warm-up: pins high through reset, rise enable right after release
        pinIn = 16'hFFFF;
        nReset = 1'b0;
        repeat (2) @(posedge clk);
        #1 nReset = 1'b1;
        apb_write(A_REN, 32'h0000_FFFF, 0, "warm_rise_en");
        idle(6);
        apb_read(A_ST,  32'h0000_0000, 0, "warm_status");
        apb_read(A_PIN, 32'h0000_FFFF, 0, "warm_pin");
        apb_read(A_OUT, 32'h0000_0000, 0, "warm_out_reset");
        check_val("warm_irq", irq, 0);
        // A real edge after warm-up is still captured
        pinIn = 16'hFFDF;
        idle(4);
        pinIn = 16'hFFFF;
        idle(4);
        apb_read(A_ST, 32'h0000_0020, 0, "post_warm_rise");

        idle(2);
        check_val("scoreboard_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpio_irq.md
# gpio_irq

Parametrised APB-slave general-purpose I/O block with per-bit direction, atomic set/clear, a two-flop input synchroniser and edge-triggered, individually maskable interrupts. It is the next generation of the 16-bit GPIO peripheral and attaches to the APB fabric as a zero-wait-state subordinate. Pins are split into separate in, out and output-enable vectors. Pad tristating happens outside the block.

## Interface
- AddrWidth, 32, APB address width
- DataWidth, 32, APB data width
- Width, 16, number of GPIO bits, 1..DataWidth
- clk  in  1  PCLK
- nReset  in  1  PRESETn. One clock; reset is synchronous and active-low.
- addr  in  AddrWidth  PADDR
- wData  in  DataWidth  PWDATA
- write  in  1  PWRITE
- sel  in  1  PSEL
- enable  in  1  PENABLE
- rData  out  DataWidth  PRDATA
- readyOut  out  1  PREADY
- subErr  out  1  PSLVERR
- pinIn  in  Width  asynchronous pad inputs
- pinOut  out  Width  output data register
- pinOe  out  Width  direction register, 1 = drive
- irq  out  1  level interrupt, |(STATUS & IRQ_EN)

## Operation
- Register map is decoded on addr[4:2]. Offsets:
  - 0x00 OUT (RW)
  - 0x04 DIR (RW)
  - 0x08 PIN (RO, synchronised input)
  - 0x0C SET (WO, OUT |= wData)
  - 0x10 CLR (WO, OUT &= ~wData)
  - 0x14 IRQ_EN (RW)
  - 0x18 RISE_EN (RW)
  - 0x1C FALL_EN (RW); STATUS is at 0x20 (RW1C), decoded with addr[5]
- Valid offsets are 0x00–0x20. Any other offset, addr[1:0] != 0, a write to PIN, or a read of SET/CLR is an error access. An error access asserts subErr, changes no state and returns rData = 0.
- Bits [DataWidth-1:Width] read 0 and are ignored on write.
- Synchroniser: s1 <= pinIn, s2 <= s1, s3 <= s2. PIN reads s2.
- Edge detect: rise = s2 & ~s3 & RISE_EN; fall = ~s2 & s3 & FALL_EN.
- STATUS: STATUS <= (STATUS & ~w1c) | rise | fall. An edge in the same cycle as a W1C of that bit wins, so the bit stays 1.
- Edge capture is independent of DIR. Output pins loop back through the pads.
- Warm-up: a 2-bit counter clears on reset and saturates at 3. Edge capture is masked until it reaches 3. This prevents spurious edges from the reset value of the sync flops.

## Timing
- APB: zero wait states. readyOut = 1 whenever sel.
- Writes commit on the clk edge where sel & enable & write & !subErr.
- rData and subErr are combinational in the access phase (sel & enable). Otherwise rData = 0 and subErr = 0.
- Write-to-pin latency: OUT/DIR/SET/CLR written on edge N are visible on pinOut/pinOe immediately after edge N.
- Input latency, for a pinIn change set up before edge N:
  - s1 updates at N, s2 at N+1, so PIN reads the new value after N+1.
  - STATUS sets at N+2, and irq asserts after N+2 if the bit is enabled.
- irq is combinational from registers, with no additional latency.
- Reset (nReset low at an edge) clears OUT, DIR, IRQ_EN, RISE_EN, FALL_EN, STATUS, s1–s3 and the warm-up counter.
- Reset outputs: pinOut = 0, pinOe = 0, irq = 0, rData = 0, subErr = 0. readyOut follows sel.
- Reset asserted mid-transfer aborts the transfer; the write does not commit.
- First edge-capture cycle is the third edge after reset deasserts.

## Structure
- gpio_irq_pkg holds:
  - register offset localparams (OFF_OUT … OFF_STATUS)
  - the warm-up count constant
  - a typedef for the decoded register-select enum
- Sub-module gpio_irq_sync (parameter Width): three-flop chain plus rise/fall vectors, with a synchronous active-low reset.
- The top holds the APB decode, the register file, the warm-up counter and the irq reduction.

## Test plan
- Reset: hold nReset low 2 cycles, then read all registers → every register reads 0x0, pinOe = 0, irq = 0.
- Set/clear: write OUT = 0x00F0, SET 0x000F, CLR 0x0030 → OUT reads 0x00CF and pinOut = 0x00CF.
- Rising interrupt: RISE_EN = 0x0001, IRQ_EN = 0x0001, drive pinIn[0] 0→1 before edge N → PIN[0] = 1 after N+1, STATUS = 0x1 and irq = 1 after N+2. Write 0x1 to STATUS → irq = 0.
- Collision: a falling edge on bit 3 lands on the same edge as a W1C of STATUS bit 3 → STATUS[3] stays 1.
- Errors: read 0x24, write 0x08, write 0x02 → each returns subErr = 1 and rData = 0, and no register changes.
- Warm-up: pinIn = 0xFFFF during and after reset with RISE_EN = all ones written right after reset → STATUS remains 0.
